pipe_rca: RTL and testbench
===========================

# pipe_rca

Parametrised, pipelined ripple-carry adder/subtractor, the successor to the fixed 4-bit combinational ripple adder. The WIDTH-bit carry chain is split into STAGES equal segments with a register after each, and the block adds a valid/ready handshake, an add/subtract mode, a signed-overflow flag and backpressure. It sits in the datapath wherever the fixed adder was used and a registered, higher-frequency result is needed, for example in counters, accumulators and address generators.

## Interface
- WIDTH, 8: operand and result width in bits; ≥ 1.
- STAGES, 2: number of pipeline segments; 1 ≤ STAGES ≤ WIDTH, and WIDTH % STAGES == 0, otherwise elaboration fails.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of the MSB.
- ovf  out  1  two's-complement signed overflow.

## Operation
- Segment width SEG = WIDTH/STAGES. Segment k covers bits [k·SEG +: SEG] and is computed in pipeline stage k.
- Effective operands: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin.
  - sub=0 gives sum = a + b + cin.
  - sub=1 gives sum = a − b − cin, modulo 2^WIDTH.
- Stage k registers:
  - the finished low sum bits;
  - the segment carry-out;
  - the not-yet-used high bits of a and b_eff (operand skew);
  - a valid bit.
- ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
- cout is the raw adder carry. For sub, cout=1 means no borrow.
- Global advance: adv = out_ready | ~out_valid.
  - in_ready = adv.
  - When adv=1, every stage register loads from its predecessor. Stage 0 loads the input beat and takes valid = in_valid.
  - When adv=0, every stage register holds.
- Bubbles (stage valid=0) propagate. Data registers of invalid stages may load, but out_valid stays 0 for them.
- No state machine. Pipeline state is the STAGES valid bits plus the data registers.

## Timing
- Latency: a beat accepted at edge n (in_valid & in_ready) appears with out_valid=1 after edge n+STAGES−1, provided no stall occurs. That is, it is visible in the cycle after STAGES edges counted from acceptance.
  - STAGES=1 is a registered adder with 1-cycle latency.
- Throughput: 1 beat per cycle while out_ready=1.
- out_valid=1 with out_ready=0: sum, cout, ovf and out_valid hold stable until the handshake completes.
- in_ready is combinational from out_ready and out_valid only. There is no path from in_valid to in_ready.
- Reset (rst=1 at an edge), including mid-stream:
  - all stage valid bits go to 0;
  - sum=0, cout=0, ovf=0, out_valid=0;
  - in-flight beats are discarded;
  - in_ready=1 in the cycle after reset deasserts.
  - A beat presented while rst=1 is dropped.
- Wrap-around: the result is modulo 2^WIDTH, and cout/ovf report the wrap. No saturation.
- Simultaneous output pop and input push in the same cycle: both are taken, with no bubble inserted.

## Structure
- Shared package pipe_rca_pkg holds:
  - the add/sub mode encoding constants (OP_ADD=1'b0, OP_SUB=1'b1);
  - a function seg_w(WIDTH, STAGES) used for the SEG computation and the elaboration check.
- One sub-module, rca_seg: a parametrised SEG-bit combinational ripple segment with inputs a, b, cin and outputs sum, cout, c_msb_in (the carry into its top bit). It is built from the existing full-adder cell.
  - pipe_rca instantiates STAGES copies.
  - Only the last copy's c_msb_in is used, for ovf.

## Test plan
- WIDTH=8, STAGES=4, no stall; a=0x7F, b=0x01, cin=0, sub=0 → 4 cycles later sum=0x80, cout=0, ovf=1.
- Subtract: a=0x05, b=0x07, cin=0, sub=1 → sum=0xFE, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, ovf=1.
- Wrap with carry-in: a=0xFF, b=0x00, cin=1, sub=0 → sum=0x00, cout=1, ovf=0.
- Back-to-back: 16 random beats, in_valid=1 and out_ready=1 continuously → one result per cycle in order, matching the reference model, with latency exactly 4.
- Backpressure: drop out_ready for 3 cycles while full → in_ready=0, outputs stable, no beat lost or duplicated. On release, results resume in order.
- Reset mid-stream with 3 beats in flight → out_valid=0 and sum=0 after the reset edge, no stale beat emerges afterwards. Repeat the directed checks with STAGES=1 and with STAGES=WIDTH=8.

Source files
------------

// File: rtl/pipe_rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor:
// mode encoding and the segment-width helper used for sizing and checking.
package pipe_rca_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Returns the per-stage segment width, or 0 when the split is not legal.
  function automatic int seg_w(input int width, input int stages);
    if (width < 1 || stages < 1 || stages > width || (width % stages) != 0) begin
      return 0;
    end
    return width / stages;
  endfunction

endpackage

// File: rtl/rca_seg.sv
// Combinational W-bit ripple-carry segment built from full-adder cells;
// also exposes the carry into its top bit for signed-overflow detection.
module rca_seg #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipe_rca.sv
// Pipelined WIDTH-bit ripple-carry adder/subtractor with STAGES register
// slices, a global-stall valid/ready handshake and signed-overflow output.
module pipe_rca
  import pipe_rca_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = seg_w(WIDTH, STAGES);

  if (SEG == 0) begin : g_bad_params
    $error("pipe_rca: WIDTH must be a positive multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  // Handshake: a beat moves on every edge where adv=1; the whole pipe
  // stalls as one when the output holds a beat the consumer refuses.
  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  assign b_eff = (sub == OP_SUB) ? ~b : b;
  assign c0    = (sub == OP_SUB) ? ~cin : cin;

  logic c_msb [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * SEG;
    localparam int RW = WIDTH - LO;

    // acc carries finished sum bits below LO and untouched A bits above.
    logic [WIDTH-1:0] acc_in;
    logic [RW-1:0]    op_b;
    logic             op_c;
    logic             op_v;
    logic [SEG-1:0]   seg_sum;
    logic             seg_co;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] acc_q;
    logic             co_q;
    logic             v_q;

    if (k == 0) begin : g_src
      assign acc_in = a;
      assign op_b   = b_eff;
      assign op_c   = c0;
      assign op_v   = in_valid;
    end else begin : g_src
      assign acc_in = g_stg[k-1].acc_q;
      assign op_b   = g_stg[k-1].g_fwd.b_q;
      assign op_c   = g_stg[k-1].co_q;
      assign op_v   = g_stg[k-1].v_q;
    end

    rca_seg #(.W(SEG)) u_seg (
      .a        (acc_in[LO +: SEG]),
      .b        (op_b[SEG-1:0]),
      .cin      (op_c),
      .sum      (seg_sum),
      .cout     (seg_co),
      .c_msb_in (c_msb[k])
    );

    always_comb begin
      acc_d            = acc_in;
      acc_d[LO +: SEG] = seg_sum;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        acc_q <= '0;
        co_q  <= 1'b0;
      end else if (adv) begin
        v_q   <= op_v;
        acc_q <= acc_d;
        co_q  <= seg_co;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [RW-SEG-1:0] b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          b_q <= '0;
        end else if (adv) begin
          b_q <= op_b[RW-1:SEG];
        end
      end
    end else begin : g_ovf
      logic ovf_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= c_msb[k] ^ seg_co;
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign sum       = g_stg[STAGES-1].acc_q;
  assign cout      = g_stg[STAGES-1].co_q;
  assign ovf       = g_stg[STAGES-1].g_ovf.ovf_q;

endmodule

// File: tb/tb_pipe_rca.sv
// Bench for pipe_rca: three 8-bit instances (4, 1 and 8 stages) exercised
// in turn with directed and random beats against an arithmetic reference.
module tb_pipe_rca;

  localparam int W  = 8;
  localparam int ND = 3;
  localparam int LAT [ND] = '{4, 1, 8};

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid    [ND];
  logic           out_ready   [ND];
  logic [W-1:0]   a_r         [ND];
  logic [W-1:0]   b_r         [ND];
  logic           cin_r       [ND];
  logic           sub_r       [ND];
  logic           in_ready_w  [ND];
  logic           out_valid_w [ND];
  logic [W-1:0]   sum_w       [ND];
  logic           cout_w      [ND];
  logic           ovf_w       [ND];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cur_s    = 0;
  logic lat_chk = 1'b0;
  logic [W+1:0] pend_exp = '0;

  // Scoreboard entries are {ovf, cout, sum}; acc_cyc_q holds accept cycles.
  logic [W+1:0] exp_q[$];
  int           acc_cyc_q[$];

  always #5 clk = ~clk;

  pipe_rca #(.WIDTH(W), .STAGES(4)) dut_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .a(a_r[0]), .b(b_r[0]), .cin(cin_r[0]), .sub(sub_r[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready[0]),
    .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0])
  );

  pipe_rca #(.WIDTH(W), .STAGES(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .a(a_r[1]), .b(b_r[1]), .cin(cin_r[1]), .sub(sub_r[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready[1]),
    .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1])
  );

  pipe_rca #(.WIDTH(W), .STAGES(8)) dut_s8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .a(a_r[2]), .b(b_r[2]), .cin(cin_r[2]), .sub(sub_r[2]),
    .out_valid(out_valid_w[2]), .out_ready(out_ready[2]),
    .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s (STAGES=%0d cyc=%0d) observed=0x%0h expected=0x%0h",
             tag, cur_s, cyc, obs, expv);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
    int ux, uy, sx, sy, c, r, sr;
    logic co, ov;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    c  = ci ? 1 : 0;
    if (!s) begin
      r  = ux + uy + c;
      sr = sx + sy + c;
      co = (r >= 256);
    end else begin
      r  = ux - uy - c;
      sr = sx - sy - c;
      co = (r >= 0);
    end
    ov = (sr > 127) || (sr < -128);
    return {ov, co, r[W-1:0]};
  endfunction

  task automatic set_beat(input int d, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic s, input logic [W+1:0] e);
    a_r[d]      = x;
    b_r[d]      = y;
    cin_r[d]    = ci;
    sub_r[d]    = s;
    in_valid[d] = 1'b1;
    pend_exp    = e;
  endtask

  task automatic set_rand(input int d);
    logic [W-1:0] x, y;
    logic ci, s;
    x  = W'($urandom_range(0, 255));
    y  = W'($urandom_range(0, 255));
    ci = 1'($urandom_range(0, 1));
    s  = 1'($urandom_range(0, 1));
    set_beat(d, x, y, ci, s, model(x, y, ci, s));
  endtask

  // One clock: score the handshakes seen before the edge, then advance.
  task automatic cycle(input int d, output logic fired);
    logic in_fire, out_fire;
    logic [W+1:0] e;
    int ac;
    #1;
    in_fire  = in_valid[d] && in_ready_w[d] && !rst;
    out_fire = out_valid_w[d] && out_ready[d];
    if (out_fire) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 32'(out_valid_w[d]), 32'd0);
      end else begin
        e  = exp_q.pop_front();
        ac = acc_cyc_q.pop_front();
        check("sum",  32'(sum_w[d]),  32'(e[W-1:0]));
        check("cout", 32'(cout_w[d]), 32'(e[W]));
        check("ovf",  32'(ovf_w[d]),  32'(e[W+1]));
        if (lat_chk) check("latency", 32'(cyc - ac), 32'(LAT[d]));
      end
    end
    if (rst) begin
      exp_q.delete();
      acc_cyc_q.delete();
    end else if (in_fire) begin
      exp_q.push_back(pend_exp);
      acc_cyc_q.push_back(cyc);
    end
    fired = in_fire;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic stream(input int d, input int n);
    logic f;
    if (!in_valid[d]) set_rand(d);
    for (int i = 0; i < n; i++) begin
      cycle(d, f);
      if (f) set_rand(d);
    end
  endtask

  task automatic drain(input int d);
    logic f;
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    for (int i = 0; i < LAT[d] + 4; i++) cycle(d, f);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_state(input int d, input string tag);
    check({tag, "_out_valid"}, 32'(out_valid_w[d]), 32'd0);
    check({tag, "_sum"},       32'(sum_w[d]),       32'd0);
    check({tag, "_cout"},      32'(cout_w[d]),      32'd0);
    check({tag, "_ovf"},       32'(ovf_w[d]),       32'd0);
    check({tag, "_in_ready"},  32'(in_ready_w[d]),  32'd1);
  endtask

  task automatic run_suite(input int d);
    logic f;
    logic [W+2:0] snap;
    cur_s = LAT[d];

    // Reset from power-up (or whatever the previous suite left behind).
    lat_chk      = 1'b0;
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    rst = 1'b1;
    cycle(d, f);
    cycle(d, f);
    rst = 1'b0;
    #1;
    check_reset_state(d, "reset");

    // Directed beats, issued back to back, with exact-latency checking.
    lat_chk = 1'b1;
    set_beat(d, 8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80}); cycle(d, f);
    set_beat(d, 8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFE}); cycle(d, f);
    set_beat(d, 8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F}); cycle(d, f);
    set_beat(d, 8'hFF, 8'h00, 1'b1, 1'b0, {1'b0, 1'b1, 8'h00}); cycle(d, f);
    set_beat(d, 8'h00, 8'h00, 1'b1, 1'b1, {1'b0, 1'b0, 8'hFF}); cycle(d, f);
    set_beat(d, 8'h80, 8'h80, 1'b0, 1'b0, {1'b1, 1'b1, 8'h00}); cycle(d, f);
    drain(d);

    // 16 random beats with in_valid and out_ready held high.
    for (int i = 0; i < 16; i++) begin
      set_rand(d);
      cycle(d, f);
      check("stream_accept", 32'(f), 32'd1);
    end
    drain(d);

    // Backpressure: fill, stall 3 cycles, release.
    lat_chk = 1'b0;
    stream(d, LAT[d] + 2);
    out_ready[d] = 1'b0;
    #1;
    check("stall_out_valid", 32'(out_valid_w[d]), 32'd1);
    check("stall_in_ready",  32'(in_ready_w[d]),  32'd0);
    snap = {out_valid_w[d], ovf_w[d], cout_w[d], sum_w[d]};
    for (int i = 0; i < 3; i++) begin
      cycle(d, f);
      check("stall_in_ready",  32'(in_ready_w[d]), 32'd0);
      check("stall_hold", 32'({out_valid_w[d], ovf_w[d], cout_w[d], sum_w[d]}), 32'(snap));
    end
    out_ready[d] = 1'b1;
    stream(d, 6);
    drain(d);

    // Reset with beats in flight; a beat offered during reset is dropped.
    stream(d, 3);
    rst = 1'b1;
    set_rand(d);
    cycle(d, f);
    rst = 1'b0;
    in_valid[d] = 1'b0;
    #1;
    check_reset_state(d, "midrst");
    for (int i = 0; i < LAT[d] + 3; i++) cycle(d, f);
    check("midrst_no_stale", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < ND; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
      a_r[i]       = '0;
      b_r[i]       = '0;
      cin_r[i]     = 1'b0;
      sub_r[i]     = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < ND; d++) run_suite(d);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
